// File: rtl/wrapper_block_addr_gen.sv
// Multi-channel block address generator: each command walks a block of packets
// that ends at the top of its channel region; active channels share one
// round-robin output port. Optional WRAPPER_BLOCK_ADDR_GEN_OVERFLOW_CHECK_EN
// rejects oversized blocks with a cmd_error pulse.
module wrapper_block_addr_gen #(
  parameter int unsigned ADDRWIDTH    = 11,
  parameter int unsigned PACKETWIDTH  = 256,
  parameter int unsigned NUM_CHANNELS = 2,
  localparam int unsigned PACKETBYTES      = (PACKETWIDTH + 7) / 8,
  localparam int unsigned PACKETSPACEWIDTH = ADDRWIDTH - $clog2(PACKETBYTES),
  localparam int unsigned CHWIDTH          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned CNTWIDTH         = PACKETSPACEWIDTH + 1
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [CHWIDTH-1:0]           cmd_channel,
  input  logic [CNTWIDTH-1:0]          cmd_packet_count,
  output logic                         addr_valid,
  input  logic                         addr_ready,
  output logic [ADDRWIDTH+CHWIDTH-1:0] addr,
  output logic [CHWIDTH-1:0]           addr_channel,
  output logic                         addr_last,
  output logic                         cmd_error,
  output logic [NUM_CHANNELS-1:0]      ch_busy
);

  localparam int unsigned REGION = 1 << ADDRWIDTH;

  typedef enum logic {IDLE, ACTIVE} ch_state_t;

  ch_state_t               st_q  [NUM_CHANNELS];
  ch_state_t               st_d  [NUM_CHANNELS];
  logic [ADDRWIDTH-1:0]    cur_q [NUM_CHANNELS];
  logic [ADDRWIDTH-1:0]    cur_d [NUM_CHANNELS];
  logic [CNTWIDTH-1:0]     rem_q [NUM_CHANNELS];
  logic [CNTWIDTH-1:0]     rem_d [NUM_CHANNELS];
  logic [CHWIDTH-1:0]      ptr_q, ptr_d;
  logic [CHWIDTH-1:0]      lock_ch_q, lock_ch_d;
  logic                    lock_q, lock_d;
  logic [CHWIDTH-1:0]      rr_grant, grant;
  logic [NUM_CHANNELS-1:0] act;
  logic                    accept, hs, overflow;
  logic [ADDRWIDTH:0]      start_w;

  always_comb begin
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      act[i] = (st_q[i] == ACTIVE);
    end
  end

  assign cmd_ready = !hreset && (32'(cmd_channel) < 32'(NUM_CHANNELS))
                     && (st_q[cmd_channel] == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign ch_busy   = hreset ? '0 : act;

  // Start so that the final packet lands exactly at the top of the region.
  assign start_w = (ADDRWIDTH+1)'(REGION) - (ADDRWIDTH+1)'(cmd_packet_count * PACKETBYTES);

  // Round-robin search from the pointer; a stalled grant is held via the lock.
  always_comb begin
    int idx;
    rr_grant = ptr_q;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % int'(NUM_CHANNELS);
      if (act[CHWIDTH'(idx)]) rr_grant = CHWIDTH'(idx);
    end
    grant = lock_q ? lock_ch_q : rr_grant;
  end

  assign addr_valid   = (|act) && !hreset;
  assign addr_channel = addr_valid ? grant : '0;
  assign addr         = addr_valid ? {grant, cur_q[grant]} : '0;
  assign addr_last    = addr_valid && (rem_q[grant] == CNTWIDTH'(1));
  assign hs           = addr_valid && addr_ready;

`ifdef WRAPPER_BLOCK_ADDR_GEN_OVERFLOW_CHECK_EN
  localparam int unsigned MAX_COUNT = 1 << PACKETSPACEWIDTH;
  logic err_q;

  assign overflow = (cmd_packet_count > CNTWIDTH'(MAX_COUNT));

  always_ff @(posedge hclk) begin
    if (hreset) err_q <= 1'b0;
    else        err_q <= accept && overflow;
  end

  assign cmd_error = err_q;
`else
  assign overflow  = 1'b0;
  assign cmd_error = 1'b0;
`endif

  // Next state for all channels, arbiter pointer and stall lock.
  always_comb begin
    for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
      st_d[i]  = st_q[i];
      cur_d[i] = cur_q[i];
      rem_d[i] = rem_q[i];
    end
    ptr_d     = ptr_q;
    lock_d    = addr_valid && !addr_ready;
    lock_ch_d = grant;

    if (hs) begin
      cur_d[grant] = cur_q[grant] + ADDRWIDTH'(PACKETBYTES);
      rem_d[grant] = rem_q[grant] - CNTWIDTH'(1);
      if (rem_q[grant] == CNTWIDTH'(1)) st_d[grant] = IDLE;
      ptr_d = CHWIDTH'((int'(grant) + 1) % int'(NUM_CHANNELS));
    end

    if (accept && !overflow && (cmd_packet_count != '0)) begin
      st_d[cmd_channel]  = ACTIVE;
      cur_d[cmd_channel] = ADDRWIDTH'(start_w);
      rem_d[cmd_channel] = cmd_packet_count;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        st_q[i]  <= IDLE;
        cur_q[i] <= '0;
        rem_q[i] <= '0;
      end
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
        st_q[i]  <= st_d[i];
        cur_q[i] <= cur_d[i];
        rem_q[i] <= rem_d[i];
      end
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

endmodule

// File: tb/tb_wrapper_block_addr_gen.sv
// Scoreboard bench for wrapper_block_addr_gen at default parameters.
module tb_wrapper_block_addr_gen;

  localparam int unsigned AW   = 11;
  localparam int unsigned CW   = 1;
  localparam int unsigned CNTW = 7;
  localparam int unsigned PB   = 32;

  typedef struct {
    logic [AW+CW-1:0] a;
    logic             last;
    logic [CW-1:0]    ch;
  } exp_t;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CW-1:0]     cmd_channel;
  logic [CNTW-1:0]   cmd_packet_count;
  logic              addr_valid;
  logic              addr_ready;
  logic [AW+CW-1:0]  addr;
  logic [CW-1:0]     addr_channel;
  logic              addr_last;
  logic              cmd_error;
  logic [1:0]        ch_busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  wrapper_block_addr_gen dut (
    .hclk             (hclk),
    .hreset           (hreset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_channel      (cmd_channel),
    .cmd_packet_count (cmd_packet_count),
    .addr_valid       (addr_valid),
    .addr_ready       (addr_ready),
    .addr             (addr),
    .addr_channel     (addr_channel),
    .addr_last        (addr_last),
    .cmd_error        (cmd_error),
    .ch_busy          (ch_busy)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected address stream of a block running alone on its channel.
  task automatic push_block(input int ch, input int cnt);
    int unsigned start;
    exp_t e;
    start = (2048 - cnt * PB) & 32'h7FF;
    for (int i = 0; i < cnt; i++) begin
      e.ch   = CW'(ch);
      e.a    = {CW'(ch), AW'(start + i * PB)};
      e.last = (i == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input int ch, input int cnt, input logic exp_ready);
    @(posedge hclk); #1;
    cmd_valid        = 1'b1;
    cmd_channel      = CW'(ch);
    cmd_packet_count = CNTW'(cnt);
    @(negedge hclk);
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
  endtask

  task automatic idle_cmd();
    @(posedge hclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge hclk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stall_check(input int n);
    repeat (n) begin
      @(negedge hclk);
      check("stall_valid", 32'(addr_valid), 32'd1);
      check("stall_addr", 32'(addr), 32'hFE0);
      check("stall_chan", 32'(addr_channel), 32'd1);
      check("stall_last", 32'(addr_last), 32'd1);
    end
  endtask

  // Scoreboard: every handshake must match the head of the expected queue.
  always @(negedge hclk) begin
    if (addr_valid && addr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_addr", 32'(addr_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("addr", 32'(addr), 32'(e.a));
        check("addr_last", 32'(addr_last), 32'(e.last));
        check("addr_channel", 32'(addr_channel), 32'(e.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_channel = '0; cmd_packet_count = '0; addr_ready = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_addr_valid", 32'(addr_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_ch_busy", 32'(ch_busy), 32'd0);
    check("rst_cmd_error", 32'(cmd_error), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_addr_last", 32'(addr_last), 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    addr_ready = 1'b1;

    // Three-packet block, latency one, busy drops after the last handshake.
    push_block(0, 3);
    issue(0, 3, 1'b1);
    idle_cmd();
    @(negedge hclk);
    check("first_latency", 32'(addr_valid), 32'd1);
    check("busy_during", 32'(ch_busy), 32'd1);
    wait_drain(10);
    @(negedge hclk);
    check("busy_after", 32'(ch_busy), 32'd0);
    check("valid_after", 32'(addr_valid), 32'd0);

    // Whole region, then an empty block.
    push_block(0, 64);
    issue(0, 64, 1'b1);
    idle_cmd();
    wait_drain(100);
    @(negedge hclk);
    issue(0, 0, 1'b1);
    idle_cmd();
    repeat (3) begin
      @(negedge hclk);
      check("zero_valid", 32'(addr_valid), 32'd0);
      check("zero_busy", 32'(ch_busy), 32'd0);
      check("zero_ready", 32'(cmd_ready), 32'd1);
    end

    // Two channels interleave round-robin.
    begin
      exp_t e;
      e.last = 1'b0; e.ch = 1'b0; e.a = 12'h7C0; exp_q.push_back(e);
      e.last = 1'b0; e.ch = 1'b1; e.a = 12'hFC0; exp_q.push_back(e);
      e.last = 1'b1; e.ch = 1'b0; e.a = 12'h7E0; exp_q.push_back(e);
      e.last = 1'b1; e.ch = 1'b1; e.a = 12'hFE0; exp_q.push_back(e);
    end
    issue(0, 2, 1'b1);
    issue(1, 2, 1'b1);
    idle_cmd();
    wait_drain(10);
    @(negedge hclk);

    // Stalled output holds its grant even when another channel activates.
    @(posedge hclk); #1;
    addr_ready = 1'b0;
    push_block(1, 1);
    push_block(0, 1);
    issue(1, 1, 1'b1);
    idle_cmd();
    stall_check(2);
    issue(1, 1, 1'b0);
    issue(0, 1, 1'b1);
    idle_cmd();
    stall_check(3);
    check("busy_both", 32'(ch_busy), 32'd3);
    @(posedge hclk); #1;
    addr_ready = 1'b1;
    wait_drain(10);
    @(negedge hclk);
    check("busy_idle", 32'(ch_busy), 32'd0);

    // Oversized block.
`ifdef WRAPPER_BLOCK_ADDR_GEN_OVERFLOW_CHECK_EN
    issue(0, 65, 1'b1);
    idle_cmd();
    @(negedge hclk);
    check("ovf_error", 32'(cmd_error), 32'd1);
    check("ovf_valid", 32'(addr_valid), 32'd0);
    @(negedge hclk);
    check("ovf_pulse", 32'(cmd_error), 32'd0);
    check("ovf_busy", 32'(ch_busy), 32'd0);
`else
    push_block(0, 65);
    issue(0, 65, 1'b1);
    idle_cmd();
    @(negedge hclk);
    check("noovf_error", 32'(cmd_error), 32'd0);
    wait_drain(100);
    @(negedge hclk);
    check("noovf_error_end", 32'(cmd_error), 32'd0);
`endif

    // Reset after two of four addresses abandons the block.
    push_block(0, 4);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    issue(0, 4, 1'b1);
    idle_cmd();
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(negedge hclk);
    check("rst_mid_valid", 32'(addr_valid), 32'd0);
    check("rst_mid_busy", 32'(ch_busy), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd0);
    check("rst_mid_addr", 32'(addr), 32'd0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    repeat (5) begin
      @(negedge hclk);
      check("post_rst_valid", 32'(addr_valid), 32'd0);
    end
    check("post_rst_busy", 32'(ch_busy), 32'd0);
    check("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrapper_block_addr_gen.md
WRAPPER_BLOCK_ADDR_GEN -- requirements
Module: wrapper_block_addr_gen

Interface
REQ-001 Parameter ADDRWIDTH, default 11, byte-address width of one channel region.
REQ-002 Parameter PACKETWIDTH, default 256, packet width in bits; PACKETBYTES = ceil(PACKETWIDTH/8); PACKETSPACEWIDTH = ADDRWIDTH - clog2(PACKETBYTES).
REQ-003 Parameter NUM_CHANNELS, default 2, number of independent regions; CHWIDTH = max(1, clog2(NUM_CHANNELS)).
REQ-004 hclk  in  1  single clock; all state updates on rising edge.
REQ-005 hreset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  block command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_channel  in  CHWIDTH  target channel of command.
REQ-009 cmd_packet_count  in  PACKETSPACEWIDTH+1  packets in block.
REQ-010 addr_valid  out  1  packet address present.
REQ-011 addr_ready  in  1  consumer accepts address.
REQ-012 addr  out  ADDRWIDTH+CHWIDTH  {channel, byte address} of packet.
REQ-013 addr_channel  out  CHWIDTH  channel of current address.
REQ-014 addr_last  out  1  final packet of block.
REQ-015 cmd_error  out  1  one-cycle pulse: accepted command rejected (overflow).
REQ-016 ch_busy  out  NUM_CHANNELS  per-channel block in progress.

Function
REQ-017 Each channel SHALL hold a state IDLE or ACTIVE, a current address register and a remaining-packet counter.
REQ-018 cmd_ready SHALL equal 1 iff the channel selected by cmd_channel is IDLE and cmd_channel < NUM_CHANNELS.
REQ-019 On command accept, start = 2^ADDRWIDTH - count*PACKETBYTES computed at ADDRWIDTH+1 bits and truncated to ADDRWIDTH; the channel SHALL enter ACTIVE next cycle with remaining = count.
REQ-020 Count 0 SHALL be accepted, SHALL leave the channel IDLE and SHALL produce no address.
REQ-021 Count 2^PACKETSPACEWIDTH SHALL give start 0 (entire region).
REQ-022 An ACTIVE channel SHALL present address {ch, cur}; on handshake, cur += PACKETBYTES, remaining -= 1; at remaining 1 addr_last=1 and the channel returns to IDLE after the handshake.
REQ-023 The last address of every block SHALL be 2^ADDRWIDTH - PACKETBYTES; addresses never wrap within a block.
REQ-024 Output arbitration SHALL be round-robin among ACTIVE channels, pointer advances past the granted channel only on handshake.
REQ-025 addr, addr_channel, addr_last SHALL be stable while addr_valid & !addr_ready; the grant SHALL not change while stalled.
REQ-026 At most one address per cycle; first address available one cycle after command accept (latency 1).
REQ-027 A new command for a channel SHALL be acceptable in the same cycle its last handshake occurs only on the following cycle (IDLE first); commands for other channels are accepted independently.

Reset
REQ-028 While hreset=1, all channels SHALL go IDLE; addr_valid, addr_last, cmd_error, ch_busy = 0; addr, addr_channel = 0; arbiter pointer = 0.
REQ-029 Reset mid-block SHALL abandon the block; no further addresses from it after reset deasserts.
REQ-030 cmd_ready SHALL be 0 during reset.

Configuration
REQ-031 Macro WRAPPER_BLOCK_ADDR_GEN_OVERFLOW_CHECK_EN SHALL enable overflow checking.
REQ-032 Defined: a command with count > 2^PACKETSPACEWIDTH SHALL be accepted, pulse cmd_error for one cycle, leave the channel IDLE, produce no addresses.
REQ-033 Undefined: cmd_error SHALL be tied 0; start is computed modulo 2^ADDRWIDTH and count used unchanged.

Verification (ADDRWIDTH=11, PACKETWIDTH=256, NUM_CHANNELS=2)
REQ-034 ch0 count 3, addr_ready=1 -> addr 0x7A0, 0x7C0, 0x7E0 on consecutive cycles, addr_last on 0x7E0, ch_busy[0] falls after.
REQ-035 ch0 count 64 -> first addr 0x000, 64 addresses, last 0x7E0; count 0 -> no addr_valid, cmd_ready stays 1.
REQ-036 ch0 count 2 then ch1 count 2, addr_ready=1 -> interleaved 0x7C0, 0xFC0, 0x7E0, 0xFE0.
REQ-037 ch1 count 1, addr_ready=0 for 5 cycles -> addr 0xFE0 held stable with addr_valid=1; second ch1 command sees cmd_ready=0.
REQ-038 With macro defined, count 65 -> cmd_error one-cycle pulse, no addresses; without macro, cmd_error never asserts.
REQ-039 hreset asserted after 2 of 4 addresses -> addr_valid=0 next cycle, ch_busy=0, no remaining addresses emitted.
